// File: rtl/instr_sequencer.sv
// Instruction sequencer: FIFO-buffered host words issued one at a time
// to the multicycle processor, with a done handshake and timeout watchdog.
module instr_sequencer #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic                       in_valid,
    input  logic [15:0]                in_data,
    output logic                       in_ready,
    output logic [15:0]                iin,
    output logic                       run,
    input  logic                       done,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     count,
    output logic [7:0]                 issued,
    output logic                       err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t         state, state_n;
    logic [15:0]    mem [DEPTH];
    logic [AW-1:0]  wptr, rptr;
    logic [7:0]     wcnt;
    logic           push, pop;
    logic           retire, timeout;
    logic           wcnt_clr, wcnt_inc;

    assign in_ready = (count < CW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign run      = (state == ISSUE);
    assign busy     = (state != IDLE);

    always_comb begin
        state_n  = state;
        pop      = 1'b0;
        retire   = 1'b0;
        timeout  = 1'b0;
        wcnt_clr = 1'b0;
        wcnt_inc = 1'b0;
        unique case (state)
            IDLE: begin
                if (count != '0) begin
                    pop     = 1'b1;
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                wcnt_clr = 1'b1;
                state_n  = WAIT;
            end
            WAIT: begin
                // done takes priority over an expiring watchdog
                if (done) begin
                    retire = 1'b1;
                    if (count != '0) begin
                        pop     = 1'b1;
                        state_n = ISSUE;
                    end else begin
                        state_n = IDLE;
                    end
                end else if (wcnt == 8'(TIMEOUT - 1)) begin
                    timeout = 1'b1;
                    state_n = IDLE;
                end else begin
                    wcnt_inc = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            wptr   <= '0;
            rptr   <= '0;
            count  <= '0;
            iin    <= 16'h0000;
            wcnt   <= '0;
            issued <= '0;
            err    <= 1'b0;
        end else begin
            state <= state_n;
            if (push)
                wptr <= wptr + 1'b1;
            if (pop) begin
                rptr <= rptr + 1'b1;
                iin  <= mem[rptr];
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (wcnt_clr)
                wcnt <= '0;
            else if (wcnt_inc)
                wcnt <= wcnt + 1'b1;
            if (retire)
                issued <= issued + 1'b1;
            if (timeout)
                err <= 1'b1;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid
    always_ff @(posedge clock) begin
        if (push)
            mem[wptr] <= in_data;
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer.
// Inputs change and outputs are sampled on the falling edge.
module tb_instr_sequencer;

    logic        clock;
    logic        resetn;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic [15:0] iin;
    logic        run;
    logic        done;
    logic        busy;
    logic [3:0]  count;
    logic [7:0]  issued;
    logic        err;

    int n_chk  = 0;
    int n_pass = 0;
    logic [15:0] exp_q [$];

    instr_sequencer #(.DEPTH(8), .TIMEOUT(15)) dut (
        .clock    (clock),
        .resetn   (resetn),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .iin      (iin),
        .run      (run),
        .done     (done),
        .busy     (busy),
        .count    (count),
        .issued   (issued),
        .err      (err)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got hang expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    task automatic push_word(input logic [15:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_run(input int budget);
        int n;
        n = 0;
        while (run !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        if (run !== 1'b1)
            chk("run_wait_expired", {31'd0, run}, 32'd1);
    endtask

    // Called with run high: step into WAIT, then retire with done
    task automatic retire_one();
        step();
        done = 1'b1;
        step();
        done = 1'b0;
    endtask

    // Starts in WAIT; retires n queued words, checking issue order
    task automatic drain(input int n);
        for (int k = 0; k < n; k++) begin
            chk("drain_iin", {16'd0, iin}, {16'd0, exp_q.pop_front()});
            done = 1'b1;
            step();
            done = 1'b0;
            if (k < n - 1) begin
                chk("drain_run", {31'd0, run}, 32'd1);
                step();
            end
        end
    endtask

    initial begin
        resetn   = 1'b0;
        in_valid = 1'b1;
        in_data  = 16'h1234;
        done     = 1'b0;

        repeat (3) step();
        chk("rst_count",    {28'd0, count},   32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_run",      {31'd0, run},     32'd0);
        chk("rst_busy",     {31'd0, busy},    32'd0);
        chk("rst_iin",      {16'd0, iin},     32'd0);
        chk("rst_issued",   {24'd0, issued},  32'd0);
        chk("rst_err",      {31'd0, err},     32'd0);
        in_valid = 1'b0;
        resetn   = 1'b1;
        step();
        chk("rel_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rel_count",    {28'd0, count},    32'd0);

        // single issue, done three cycles after run
        push_word(16'hA001);
        chk("one_count", {28'd0, count}, 32'd1);
        chk("one_run0",  {31'd0, run},   32'd0);
        step();
        chk("one_run1",  {31'd0, run},   32'd1);
        chk("one_iin",   {16'd0, iin},   32'hA001);
        chk("one_busy",  {31'd0, busy},  32'd1);
        step();
        chk("one_pulse", {31'd0, run},   32'd0);
        step();
        step();
        done = 1'b1;
        step();
        done = 1'b0;
        chk("one_issued", {24'd0, issued}, 32'd1);
        chk("one_idle",   {31'd0, busy},   32'd0);
        chk("one_hold",   {16'd0, iin},    32'hA001);

        // stream: A400 issues at once, A401..A408 fill, A409 rejected
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = 16'hA400 + 16'(i);
            step();
            if (i == 8) begin
                chk("full_count", {28'd0, count},    32'd8);
                chk("full_ready", {31'd0, in_ready}, 32'd0);
            end
        end
        in_valid = 1'b0;
        chk("full_reject", {28'd0, count}, 32'd8);
        for (int i = 0; i < 9; i++)
            exp_q.push_back(16'hA400 + 16'(i));
        drain(9);
        chk("stream_count",  {28'd0, count},  32'd0);
        chk("stream_issued", {24'd0, issued}, 32'd10);
        chk("stream_idle",   {31'd0, busy},   32'd0);

        // push offered in the pop cycle while full
        for (int i = 0; i < 9; i++)
            push_word(16'hB000 + 16'(i));
        chk("cc_full", {28'd0, count}, 32'd8);
        in_valid = 1'b1;
        in_data  = 16'hB0FF;
        done     = 1'b1;
        chk("cc_ready0", {31'd0, in_ready}, 32'd0);
        step();
        done = 1'b0;
        chk("cc_count7", {28'd0, count},    32'd7);
        chk("cc_ready1", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        chk("cc_count8", {28'd0, count}, 32'd8);
        for (int i = 1; i < 9; i++)
            exp_q.push_back(16'hB000 + 16'(i));
        exp_q.push_back(16'hB0FF);
        drain(9);
        chk("cc_issued", {24'd0, issued}, 32'd20);
        chk("cc_empty",  {28'd0, count},  32'd0);

        // timeout at the 15th WAIT edge
        push_word(16'h4400);
        repeat (16) step();
        chk("to_err0",  {31'd0, err},  32'd0);
        chk("to_busy1", {31'd0, busy}, 32'd1);
        step();
        chk("to_err1",    {31'd0, err},    32'd1);
        chk("to_idle",    {31'd0, busy},   32'd0);
        chk("to_issued",  {24'd0, issued}, 32'd20);
        chk("to_iin",     {16'd0, iin},    32'h4400);
        push_word(16'h8400);
        wait_run(10);
        chk("post_iin", {16'd0, iin}, 32'h8400);
        retire_one();
        chk("post_issued", {24'd0, issued}, 32'd21);
        chk("post_err",    {31'd0, err},    32'd1);

        // reset in WAIT with three words queued
        for (int i = 0; i < 4; i++)
            push_word(16'hC000 + 16'(i));
        chk("mr_count", {28'd0, count}, 32'd3);
        chk("mr_busy",  {31'd0, busy},  32'd1);
        resetn = 1'b0;
        #1;
        chk("mr_run",    {31'd0, run},    32'd0);
        chk("mr_count0", {28'd0, count},  32'd0);
        chk("mr_iin",    {16'd0, iin},    32'd0);
        chk("mr_idle",   {31'd0, busy},   32'd0);
        chk("mr_err",    {31'd0, err},    32'd0);
        chk("mr_issued", {24'd0, issued}, 32'd0);
        step();
        step();
        resetn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("mr_norun", {31'd0, run}, 32'd0);
        end
        chk("mr_empty", {28'd0, count}, 32'd0);

        // 256 retires wrap the counter
        for (int i = 0; i < 256; i++) begin
            push_word(16'(i));
            wait_run(10);
            retire_one();
            if (i == 254)
                chk("wrap_255", {24'd0, issued}, 32'd255);
        end
        chk("wrap_0", {24'd0, issued}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
